// File: rtl/sint_peak_tracker_pkg.sv
// Shared types and defaults for the signed peak tracker.
package sint_peak_tracker_pkg;

  localparam int unsigned DefWidth    = 7;
  localparam int unsigned DefCntWidth = 8;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccum  = 2'd1,
    StReport = 2'd2
  } state_e;

  // Result record at the default widths, for consumers built around the defaults.
  typedef struct packed {
    logic [DefWidth-1:0]    max;
    logic [DefWidth-1:0]    min;
    logic [DefCntWidth-1:0] max_idx;
    logic [DefCntWidth-1:0] count;
    logic                   ovf;
  } result_t;

endpackage

// File: rtl/sint_cmp_update.sv
// Signed running max/min update for one incoming sample.
module sint_cmp_update #(
  parameter int unsigned WIDTH = 7
) (
  input  logic [WIDTH-1:0] max_i,
  input  logic [WIDTH-1:0] min_i,
  input  logic [WIDTH-1:0] sample_i,
  output logic [WIDTH-1:0] max_o,
  output logic [WIDTH-1:0] min_o,
  output logic             gt_o,
  output logic             lt_o
);

  // Strict comparisons: ties keep the existing extreme and its index.
  assign gt_o  = $signed(sample_i) > $signed(max_i);
  assign lt_o  = $signed(sample_i) < $signed(min_i);
  assign max_o = gt_o ? sample_i : max_i;
  assign min_o = lt_o ? sample_i : min_i;

endmodule

// File: rtl/sint_peak_tracker.sv
// Per-frame signed max/min/argmax/count over a valid/ready sample stream.
module sint_peak_tracker
  import sint_peak_tracker_pkg::*;
#(
  parameter int unsigned WIDTH     = DefWidth,
  parameter int unsigned CNT_WIDTH = DefCntWidth
) (
  input  logic                 CLK,
  input  logic                 ASYNCRESETN,
  input  logic                 I_valid,
  output logic                 I_ready,
  input  logic [WIDTH-1:0]     I_data,
  input  logic                 I_last,
  output logic                 O_valid,
  input  logic                 O_ready,
  output logic [WIDTH-1:0]     O_max,
  output logic [WIDTH-1:0]     O_min,
  output logic [CNT_WIDTH-1:0] O_max_idx,
  output logic [CNT_WIDTH-1:0] O_count,
  output logic                 O_ovf
);

  typedef struct packed {
    logic [WIDTH-1:0]     max;
    logic [WIDTH-1:0]     min;
    logic [CNT_WIDTH-1:0] max_idx;
    logic [CNT_WIDTH-1:0] count;
    logic                 ovf;
  } res_t;

  state_e state_q, state_d;
  res_t   acc_q, acc_d;
  res_t   out_q, out_d;

  logic                 in_xfer;
  logic                 finish;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic [WIDTH-1:0]     cmp_max, cmp_min;
  logic                 cmp_gt, cmp_lt;

  sint_cmp_update #(
    .WIDTH(WIDTH)
  ) u_cmp (
    .max_i   (acc_q.max),
    .min_i   (acc_q.min),
    .sample_i(I_data),
    .max_o   (cmp_max),
    .min_o   (cmp_min),
    .gt_o    (cmp_gt),
    .lt_o    (cmp_lt)
  );

  assign I_ready = (state_q != StReport);
  assign O_valid = (state_q == StReport);
  assign in_xfer = I_valid && I_ready;
  assign cnt_inc = acc_q.count + 1'b1;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    finish  = 1'b0;
    case (state_q)
      StIdle: begin
        if (in_xfer) begin
          acc_d.max     = I_data;
          acc_d.min     = I_data;
          acc_d.max_idx = '0;
          acc_d.count   = '0;
          acc_d.ovf     = 1'b0;
          if (I_last) begin
            state_d = StReport;
            finish  = 1'b1;
          end else begin
            state_d = StAccum;
          end
        end
      end
      StAccum: begin
        if (in_xfer) begin
          acc_d.count = cnt_inc;
          if (cmp_gt) begin
            acc_d.max     = cmp_max;
            acc_d.max_idx = cnt_inc;
          end
          if (cmp_lt) acc_d.min = cmp_min;
          if (I_last) begin
            state_d = StReport;
            finish  = 1'b1;
          end else if (cnt_inc == {CNT_WIDTH{1'b1}}) begin
            // Frame is full but not ended: truncate, the rest forms a new frame.
            acc_d.ovf = 1'b1;
            state_d   = StReport;
            finish    = 1'b1;
          end
        end
      end
      StReport: begin
        if (O_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    out_d = finish ? acc_d : out_q;
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state_q <= StIdle;
      acc_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
    end
  end

  assign O_max     = out_q.max;
  assign O_min     = out_q.min;
  assign O_max_idx = out_q.max_idx;
  assign O_count   = out_q.count;
  assign O_ovf     = out_q.ovf;

endmodule

// File: tb/tb_sint_peak_tracker.sv
// Directed bench for sint_peak_tracker (WIDTH=7, CNT_WIDTH=3).
module tb_sint_peak_tracker;

  logic       CLK = 1'b0;
  logic       ASYNCRESETN = 1'b0;
  logic       I_valid = 1'b0;
  logic       I_ready;
  logic [6:0] I_data = '0;
  logic       I_last = 1'b0;
  logic       O_valid;
  logic       O_ready = 1'b0;
  logic [6:0] O_max, O_min;
  logic [2:0] O_max_idx, O_count;
  logic       O_ovf;

  int checks = 0;
  int errors = 0;

  sint_peak_tracker #(
    .WIDTH    (7),
    .CNT_WIDTH(3)
  ) dut (
    .CLK        (CLK),
    .ASYNCRESETN(ASYNCRESETN),
    .I_valid    (I_valid),
    .I_ready    (I_ready),
    .I_data     (I_data),
    .I_last     (I_last),
    .O_valid    (O_valid),
    .O_ready    (O_ready),
    .O_max      (O_max),
    .O_min      (O_min),
    .O_max_idx  (O_max_idx),
    .O_count    (O_count),
    .O_ovf      (O_ovf)
  );

  always #5 CLK = ~CLK;

  // Result tuple: {O_valid, O_max, O_min, O_max_idx, O_count, O_ovf}
  wire [21:0] res = {O_valid, O_max, O_min, O_max_idx, O_count, O_ovf};

  task automatic send(input int d, input logic last);
    int n;
    @(negedge CLK);
    I_valid = 1'b1;
    I_data  = d[6:0];
    I_last  = last;
    n = 0;
    while (!I_ready && n < 20) begin
      @(negedge CLK);
      n++;
    end
    if (!I_ready) begin
      checks++;
      errors++;
      $display("FAIL send_wait: I_ready stuck at %0b, required 1", I_ready);
    end
    @(posedge CLK);
    #1;
    I_valid = 1'b0;
    I_last  = 1'b0;
  endtask

  task automatic drain();
    @(negedge CLK);
    O_ready = 1'b1;
    @(posedge CLK);
    #1;
    O_ready = 1'b0;
    checks++;
    if ({O_valid, I_ready} !== 2'b01) begin
      errors++;
      $display("FAIL drain: valid/ready got %b required 01", {O_valid, I_ready});
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({res, I_ready} !== {22'h0, 1'b1}) begin
      errors++;
      $display("FAIL reset: got %h/%b required 0/1", res, I_ready);
    end
    @(negedge CLK);
    ASYNCRESETN = 1'b1;
  endtask

  task automatic test_basic_frame();
    logic [21:0] exp_r;
    send(5, 0); send(-3, 0); send(12, 0); send(12, 0);
    checks++;
    if (O_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_early_valid: got %b required 0", O_valid);
    end
    send(-64, 1);
    exp_r = {1'b1, 7'd12, 7'h40, 3'd2, 3'd4, 1'b0};
    checks++;
    if (res !== exp_r) begin
      errors++;
      $display("FAIL basic_frame: got %h required %h", res, exp_r);
    end
    drain();
  endtask

  task automatic test_single();
    logic [21:0] exp_r;
    send(-1, 1);
    exp_r = {1'b1, 7'h7f, 7'h7f, 3'd0, 3'd0, 1'b0};
    checks++;
    if (res !== exp_r) begin
      errors++;
      $display("FAIL single_sample: got %h required %h", res, exp_r);
    end
    drain();
  endtask

  task automatic test_extremes();
    logic [21:0] exp_r;
    send(63, 0); send(-64, 0); send(0, 1);
    exp_r = {1'b1, 7'd63, 7'h40, 3'd0, 3'd2, 1'b0};
    checks++;
    if (res !== exp_r) begin
      errors++;
      $display("FAIL signed_extremes: got %h required %h", res, exp_r);
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [21:0] exp_r;
    logic [21:0] exp_n;
    send(-10, 0); send(30, 1);
    exp_r = {1'b1, 7'd30, 7'h76, 3'd1, 3'd1, 1'b0};
    @(negedge CLK);
    I_valid = 1'b1;
    I_data  = 7'd9;
    I_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK);
      #1;
      checks++;
      if ({res, I_ready} !== {exp_r, 1'b0}) begin
        errors++;
        $display("FAIL backpressure_hold%0d: got %h/%b required %h/0", i, res, I_ready, exp_r);
      end
    end
    O_ready = 1'b1;
    @(posedge CLK);
    #1;
    O_ready = 1'b0;
    checks++;
    if ({O_valid, I_ready, O_max} !== {2'b01, 7'd30}) begin
      errors++;
      $display("FAIL backpressure_release: got %b/%b/%0d required 0/1/30", O_valid, I_ready,
               O_max);
    end
    @(posedge CLK);
    #1;
    I_valid = 1'b0;
    I_last  = 1'b0;
    exp_n = {1'b1, 7'd9, 7'd9, 3'd0, 3'd0, 1'b0};
    checks++;
    if (res !== exp_n) begin
      errors++;
      $display("FAIL backpressure_next: got %h required %h", res, exp_n);
    end
    drain();
  endtask

  task automatic test_full_frame();
    logic [21:0] exp_r;
    for (int i = 0; i < 7; i++) send(1, 0);
    send(1, 1);
    exp_r = {1'b1, 7'd1, 7'd1, 3'd0, 3'd7, 1'b0};
    checks++;
    if (res !== exp_r) begin
      errors++;
      $display("FAIL full_frame_no_ovf: got %h required %h", res, exp_r);
    end
    drain();
  endtask

  task automatic test_overflow();
    logic [21:0] exp_r;
    send(3, 0); send(-5, 0); send(20, 0); send(20, 0);
    send(-30, 0); send(7, 0); send(0, 0);
    checks++;
    if (O_valid !== 1'b0) begin
      errors++;
      $display("FAIL overflow_early: got %b required 0", O_valid);
    end
    send(-2, 0);
    exp_r = {1'b1, 7'd20, 7'h62, 3'd2, 3'd7, 1'b1};
    checks++;
    if (res !== exp_r) begin
      errors++;
      $display("FAIL overflow: got %h required %h", res, exp_r);
    end
    drain();
    send(50, 1);
    exp_r = {1'b1, 7'd50, 7'd50, 3'd0, 3'd0, 1'b0};
    checks++;
    if (res !== exp_r) begin
      errors++;
      $display("FAIL overflow_new_frame: got %h required %h", res, exp_r);
    end
    drain();
  endtask

  task automatic test_reset_mid_frame();
    logic [21:0] exp_r;
    send(60, 0); send(-60, 0);
    #2;
    ASYNCRESETN = 1'b0;
    #1;
    checks++;
    if ({res, I_ready} !== {22'h0, 1'b1}) begin
      errors++;
      $display("FAIL reset_mid_accum: got %h/%b required 0/1", res, I_ready);
    end
    @(negedge CLK);
    ASYNCRESETN = 1'b1;
    send(2, 0); send(4, 1);
    exp_r = {1'b1, 7'd4, 7'd2, 3'd1, 3'd1, 1'b0};
    checks++;
    if (res !== exp_r) begin
      errors++;
      $display("FAIL after_reset_frame: got %h required %h", res, exp_r);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_single();
    test_extremes();
    test_backpressure();
    test_full_frame();
    test_overflow();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
